tick_period_meter: RTL and testbench

Measures the spacing of a periodic tick, in `mclk` cycles, on the receiving end of the clock-divider tick outputs (10 ms / 1 ms / 100 ms strobes, or divided level clocks such as the 190 Hz one). It reports each measured period, flags periods outside a tolerance window, detects loss of the tick, and keeps lock/min/max/count statistics. It sits beside the divider as a self-check and feeds debug LEDs and the CPU status registers.

---
 rtl/tick_period_meter.sv | 200 ++++++++++++++++++++
 tb/tb_tick_period_meter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures tick spacing in mclk cycles, flags
// out-of-tolerance periods, detects tick loss, keeps lock/min/max/count.
// Optional macro TICK_SYNC_EN: tick_in is an async level clock
// (2-flop sync + edge detect, t_ev = rising edge); otherwise tick_in
// is a same-domain strobe used directly as the tick event.
// Ports:
//   mclk, clr_n (async active-low) : clock / reset
//   tick_in                        : tick under test
//   clear_stats                    : reinitialise count/min/max/sticky
//   period, period_valid, period_err : last period, update pulse, error
//   err_sticky, lost, locked       : status flags
//   tick_count, min_period, max_period : statistics since clear
module tick_period_meter #(
   parameter int unsigned W          = 32,
   parameter int unsigned EXP_PERIOD = 100000,
   parameter int unsigned TOL        = 16
) (
   input  logic         mclk,
   input  logic         clr_n,
   input  logic         tick_in,
   input  logic         clear_stats,
   output logic [W-1:0] period,
   output logic         period_valid,
   output logic         period_err,
   output logic         err_sticky,
   output logic         lost,
   output logic         locked,
   output logic [15:0]  tick_count,
   output logic [W-1:0] min_period,
   output logic [W-1:0] max_period
);

   typedef enum logic [1:0] {ARM, MEAS, LOST} state_t;

   localparam logic [W-1:0]        LIM   = W'(EXP_PERIOD + TOL);
   localparam logic signed [W:0]   EXP_S = (W+1)'(EXP_PERIOD);
   localparam logic signed [W:0]   TOL_S = (W+1)'(TOL);

   logic t_ev;

`ifdef TICK_SYNC_EN
   // s1/s2 synchronise, s3 holds the previous level, ev_q is the
   // registered rising edge so a long high level is one event.
   logic s1_q, s2_q, s3_q, ev_q;
   always_ff @(posedge mclk or negedge clr_n) begin
      if (!clr_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
         ev_q <= 1'b0;
      end else begin
         s1_q <= tick_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
         ev_q <= s2_q & ~s3_q;
      end
   end
   assign t_ev = ev_q;
`else
   assign t_ev = tick_in;
`endif

   state_t        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]  period_q, period_d;
   logic          pv_q, pv_d;
   logic          perr_q, perr_d;
   logic          sticky_q, sticky_d;
   logic          lost_q, lost_d;
   logic [1:0]    run_q, run_d;
   logic          locked_q, locked_d;
   logic [15:0]   tc_q, tc_d;
   logic [W-1:0]  min_q, min_d;
   logic [W-1:0]  max_q, max_d;

   logic [W-1:0]     meas;
   logic signed [W:0] diff, absd;
   logic          bad;
   logic          rep;
   logic          arm_tick;
   logic [15:0]   tc_b;
   logic [W-1:0]  min_b, max_b;
   logic          sticky_b;

   // Difference taken one bit wider so it can never overflow.
   assign meas = cnt_q + 1'b1;
   assign diff = $signed({1'b0, meas}) - EXP_S;
   assign absd = diff[W] ? -diff : diff;
   assign bad  = absd > TOL_S;

   always_ff @(posedge mclk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= ARM;
         cnt_q    <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         perr_q   <= 1'b0;
         sticky_q <= 1'b0;
         lost_q   <= 1'b0;
         run_q    <= 2'd0;
         locked_q <= 1'b0;
         tc_q     <= 16'd0;
         min_q    <= '1;
         max_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         perr_q   <= perr_d;
         sticky_q <= sticky_d;
         lost_q   <= lost_d;
         run_q    <= run_d;
         locked_q <= locked_d;
         tc_q     <= tc_d;
         min_q    <= min_d;
         max_q    <= max_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      pv_d     = 1'b0;
      perr_d   = 1'b0;
      run_d    = run_q;
      rep      = 1'b0;
      arm_tick = 1'b0;

      if (t_ev)
         cnt_d = '0;
      else if (cnt_q == '1)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 1'b1;

      unique case (state_q)
         ARM: begin
            if (t_ev) begin
               state_d  = MEAS;
               arm_tick = 1'b1;
            end
         end
         MEAS: begin
            if (t_ev) begin
               rep      = 1'b1;
               period_d = meas;
               pv_d     = 1'b1;
               perr_d   = bad;
               if (bad)
                  run_d = 2'd0;
               else if (run_q != 2'd2)
                  run_d = run_q + 2'd1;
            end else if (cnt_q >= LIM) begin
               state_d = LOST;
               run_d   = 2'd0;
            end
         end
         LOST: begin
            if (t_ev) begin
               state_d  = MEAS;
               arm_tick = 1'b1;
            end
         end
         default: state_d = ARM;
      endcase

      // Clear first, then fold in this cycle's sample on top of it.
      tc_b     = clear_stats ? 16'd0 : tc_q;
      min_b    = clear_stats ? '1    : min_q;
      max_b    = clear_stats ? '0    : max_q;
      sticky_b = clear_stats ? 1'b0  : sticky_q;

      tc_d     = tc_b + {15'd0, rep | arm_tick};
      min_d    = min_b;
      max_d    = max_b;
      sticky_d = sticky_b;
      if (rep) begin
         if (meas < min_b) min_d = meas;
         if (meas > max_b) max_d = meas;
         sticky_d = sticky_b | bad;
      end
      // Loss wins over a concurrent clear.
      if (state_d == LOST) sticky_d = 1'b1;

      lost_d   = (state_d == LOST);
      locked_d = (run_d == 2'd2);
   end

   assign period       = period_q;
   assign period_valid = pv_q;
   assign period_err   = perr_q;
   assign err_sticky   = sticky_q;
   assign lost         = lost_q;
   assign locked       = locked_q;
   assign tick_count   = tc_q;
   assign min_period   = min_q;
   assign max_period   = max_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: directed checks of tick_period_meter.
// Strobe mode by default; level-clock mode when TICK_SYNC_EN is defined.
module tb_tick_period_meter;

   localparam int unsigned W = 16;
`ifdef TICK_SYNC_EN
   localparam int unsigned EXP = 200;
`else
   localparam int unsigned EXP = 100;
`endif
   localparam int unsigned TOL = 2;

   logic          mclk = 1'b0;
   logic          clr_n = 1'b0;
   logic          tick_in = 1'b0;
   logic          clear_stats = 1'b0;
   logic [W-1:0]  period;
   logic          period_valid, period_err, err_sticky, lost, locked;
   logic [15:0]   tick_count;
   logic [W-1:0]  min_period, max_period;

   int total = 0;
   int bad = 0;

   tick_period_meter #(.W(W), .EXP_PERIOD(EXP), .TOL(TOL)) dut (
      .mclk(mclk), .clr_n(clr_n), .tick_in(tick_in),
      .clear_stats(clear_stats), .period(period),
      .period_valid(period_valid), .period_err(period_err),
      .err_sticky(err_sticky), .lost(lost), .locked(locked),
      .tick_count(tick_count), .min_period(min_period),
      .max_period(max_period)
   );

   always #5 mclk = ~mclk;

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse();
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
   endtask

   // Tick edges spaced n cycles apart from the previous pulse.
   task automatic gap(input int n);
      for (int i = 0; i < n - 1; i++) step();
      pulse();
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_period"}, 32'(period), 0);
      chk({p, "_pv"}, 32'(period_valid), 0);
      chk({p, "_perr"}, 32'(period_err), 0);
      chk({p, "_sticky"}, 32'(err_sticky), 0);
      chk({p, "_lost"}, 32'(lost), 0);
      chk({p, "_locked"}, 32'(locked), 0);
      chk({p, "_tc"}, 32'(tick_count), 0);
      chk({p, "_min"}, 32'(min_period), 32'hFFFF);
      chk({p, "_max"}, 32'(max_period), 0);
   endtask

   initial begin
      step();
      step();
      chk_reset("rst");
      clr_n = 1'b1;
      step();

`ifdef TICK_SYNC_EN
      for (int r = 0; r < 4; r++) begin
         tick_in = 1'b1;
         for (int i = 1; i <= 200; i++) begin
            step();
            if (r >= 1 && i == 3) chk("sync_pv_early", 32'(period_valid), 0);
            if (r >= 1 && i == 4) begin
               chk("sync_pv", 32'(period_valid), 1);
               chk("sync_period", 32'(period), 200);
            end
            if (i == 100) tick_in = 1'b0;
         end
      end
      chk("sync_tc", 32'(tick_count), 4);
      chk("sync_locked", 32'(locked), 1);
`else
      pulse();
      chk("arm_pv", 32'(period_valid), 0);
      chk("arm_tc", 32'(tick_count), 1);
      gap(100);
      chk("p2_pv", 32'(period_valid), 1);
      chk("p2_period", 32'(period), 100);
      chk("p2_err", 32'(period_err), 0);
      chk("p2_locked", 32'(locked), 0);
      gap(100);
      chk("p3_locked", 32'(locked), 1);
      chk("p3_tc", 32'(tick_count), 3);
      gap(103);
      chk("p103_period", 32'(period), 103);
      chk("p103_err", 32'(period_err), 1);
      chk("p103_sticky", 32'(err_sticky), 1);
      chk("p103_locked", 32'(locked), 0);
      gap(98);
      chk("p98_period", 32'(period), 98);
      chk("p98_err", 32'(period_err), 0);
      chk("p98_min", 32'(min_period), 98);
      chk("p98_max", 32'(max_period), 103);
      step();
      chk("pv_pulse_end", 32'(period_valid), 0);
      gap(99);
      gap(100);
      chk("relock", 32'(locked), 1);
      for (int i = 0; i < 102; i++) step();
      chk("lost_before", 32'(lost), 0);
      step();
      chk("lost_rise", 32'(lost), 1);
      chk("lost_locked", 32'(locked), 0);
      chk("lost_sticky", 32'(err_sticky), 1);
      for (int i = 0; i < 5; i++) step();
      pulse();
      chk("restart_lost", 32'(lost), 0);
      chk("restart_pv", 32'(period_valid), 0);
      gap(100);
      chk("after_lost_pv", 32'(period_valid), 1);
      chk("after_lost_period", 32'(period), 100);
      for (int i = 0; i < 98; i++) step();
      tick_in = 1'b1;
      clear_stats = 1'b1;
      step();
      tick_in = 1'b0;
      clear_stats = 1'b0;
      chk("clr_period", 32'(period), 99);
      chk("clr_tc", 32'(tick_count), 1);
      chk("clr_min", 32'(min_period), 99);
      chk("clr_max", 32'(max_period), 99);
      chk("clr_sticky", 32'(err_sticky), 0);
      for (int i = 0; i < 50; i++) step();
      clr_n = 1'b0;
      #1;
      chk_reset("async");
      @(posedge mclk);
      #1;
      clr_n = 1'b1;
      step();
      pulse();
      chk("rel_arm_pv", 32'(period_valid), 0);
      chk("rel_arm_tc", 32'(tick_count), 1);
      gap(100);
      chk("rel_period", 32'(period), 100);
      pulse();
      chk("b2b_period", 32'(period), 1);
      chk("b2b_err", 32'(period_err), 1);
      pulse();
      chk("b2b2_period", 32'(period), 1);
      chk("b2b2_pv", 32'(period_valid), 1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
